// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode/funct constants, ALU control codes and ALU-decoder op selects.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10
    } state_t;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes (Instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl codes
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // What the FSM asks of the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: turns the FSM's coarse ALU request plus the R-type funct
// field into the 4-bit ALUControl code. Purely combinational.
module mc_aludec
    import mc_controller_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    // Map the requested operation (or funct for R-type) to an ALU code
    always_comb begin
        // NOTE: default assignment first so every path drives the output and no latch is inferred.
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;  // unknown funct runs as add
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM. Moore decode of all datapath controls from
// the current state; only PCEn (branch & Zero) and ALUControl (funct in
// EXECUTE) look at datapath inputs.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       PCSrc,
    output logic       MemToReg,
    output logic       IorD,
    output logic       MemWrite,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;
    logic   irwrite_raw;
    logic   regwrite_raw;
    logic   memwrite_raw;

    assign state = state_q;

    // State register; reset returns to FETCH and aborts any instruction
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for registered state avoid read/write races between processes.
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state sequencing; opcode is consulted only in DECODE and MEMADR
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    default:      state_d = S_FETCH;  // unsupported: nop
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;  // writeback states, BRANCH, illegal codes
        endcase
    end

    // Per-state control decode; anything not named here stays 0 / add
    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        RegDst       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        aluop        = ALUOP_ADD;
        PCSrc        = 1'b0;
        MemToReg     = 1'b0;
        IorD         = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
            end
            S_DECODE:   ALUSrcB = 2'b11;  // branch target into ALUOut
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemToReg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                IorD         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_SUB;
                PCSrc   = 1'b1;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB:   regwrite_raw = 1'b1;
            default: ;  // illegal encodings: everything idle
        endcase
    end

    // Architectural write enables are held off for as long as reset is high
    assign PCEn     = ~reset & (pcwrite | (branch & Zero));
    assign IRWrite  = ~reset & irwrite_raw;
    assign RegWrite = ~reset & regwrite_raw;
    assign MemWrite = ~reset & memwrite_raw;

    mc_aludec u_aludec (
        .aluop       (aluop),
        .funct       (funct),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instructions from the test plan, then a
// randomized instruction stream, all checked every cycle against an
// instruction-level model of the control sequence.
module tb_mc_controller;

    logic       clk = 1'b1;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       PCEn, IRWrite, RegWrite, RegDst, ALUSrcA, PCSrc, MemToReg, IorD, MemWrite;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .Zero       (Zero),
        .PCEn       (PCEn),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .MemToReg   (MemToReg),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .state      (state)
    );

    typedef enum int {M_NONE, M_RESET, M_FULL} mode_t;
    typedef int iq_t[$];

    typedef struct packed {
        logic [3:0] st;
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluctl;
        logic       pcsrc;
        logic       memtoreg;
        logic       iord;
        logic       memwrite;
    } outs_t;

    int    errors = 0;
    int    checks = 0;
    mode_t exp_mode = M_NONE;
    outs_t exp_o;
    bit    exp_state_known;
    int    trace[$];
    int    regwrite_seen = 0;
    int    memwrite_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Instruction-level view: which states an opcode walks through
    function automatic iq_t states_for(input logic [5:0] op);
        iq_t q;
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b001000: q = '{0, 1, 9, 10};
            default:   q = '{0, 1};
        endcase
        return q;
    endfunction

    function automatic logic [3:0] alu_for_funct(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    // Control outputs the datapath needs in each step of an instruction
    function automatic outs_t model(input int st, input logic [5:0] fn, input logic z);
        outs_t o;
        o        = '0;
        o.st     = 4'(st);
        o.aluctl = 4'b0010;
        case (st)
            0: begin o.alusrcb = 2'b01; o.irwrite = 1'b1; o.pcen = 1'b1; end
            1: o.alusrcb = 2'b11;
            2: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            3: o.iord = 1'b1;
            4: begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            5: begin o.iord = 1'b1; o.memwrite = 1'b1; end
            6: begin o.alusrca = 1'b1; o.aluctl = alu_for_funct(fn); end
            7: begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            8: begin o.alusrca = 1'b1; o.aluctl = 4'b0110; o.pcsrc = 1'b1; o.pcen = z; end
            9: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            10: o.regwrite = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Compare process: checks DUT outputs mid-cycle against the current expectation
    always @(negedge clk) begin
        outs_t act;
        act = {state, PCEn, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB,
               ALUControl, PCSrc, MemToReg, IorD, MemWrite};
        if (RegWrite === 1'b1) regwrite_seen++;
        if (MemWrite === 1'b1) memwrite_seen++;
        case (exp_mode)
            M_FULL: begin
                trace.push_back(int'(state));
                check($sformatf("outputs@state%0d", exp_o.st), 32'(act), 32'(exp_o));
            end
            M_RESET: begin
                check("reset_enables", {28'd0, PCEn, IRWrite, RegWrite, MemWrite}, 32'd0);
                if (exp_state_known) check("reset_state", 32'(state), 32'(exp_o.st));
            end
            default: ;
        endcase
    end

    task automatic step(input mode_t m, input outs_t o);
        exp_mode = m;
        exp_o    = o;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n cycles; cur is the state at assertion (-1 if unknown)
    task automatic do_reset(input int n, input int cur);
        outs_t o;
        o     = '0;
        reset = 1'b1;
        exp_state_known = (cur >= 0);
        o.st  = 4'(cur);
        step(M_RESET, o);
        exp_state_known = 1'b1;
        o.st  = 4'd0;
        for (int i = 1; i < n; i++) step(M_RESET, o);
        reset = 1'b0;
    endtask

    // zmode: 0/1 force Zero, 2 random every cycle
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        iq_t seq;
        seq    = states_for(op);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < seq.size(); i++) begin
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            step(M_FULL, model(seq[i], fn, Zero));
        end
    endtask

    task automatic check_trace(input string name, input iq_t want);
        check({name, "_len"}, 32'(trace.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < trace.size(); i++)
            check($sformatf("%s_state%0d", name, i), 32'(trace[i]), 32'(want[i]));
        trace.delete();
    endtask

    initial begin
        int rw0;
        int mw0;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] fn_list[5];
        fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset  = 1'b1;
        opcode = 6'd0;
        funct  = 6'd0;
        Zero   = 1'b0;
        do_reset(2, -1);
        trace.delete();

        // lw: five cycles, one register write
        rw0 = regwrite_seen; mw0 = memwrite_seen;
        run_instr(6'b100011, 6'd0, 2);
        check_trace("lw", '{0, 1, 2, 3, 4});
        check("lw_regwrites", 32'(regwrite_seen - rw0), 32'd1);

        // sw: four cycles, one memory write, no register write
        rw0 = regwrite_seen; mw0 = memwrite_seen;
        run_instr(6'b101011, 6'd0, 2);
        check_trace("sw", '{0, 1, 2, 5});
        check("sw_memwrites", 32'(memwrite_seen - mw0), 32'd1);
        check("sw_regwrites", 32'(regwrite_seen - rw0), 32'd0);

        // R-type sub then slt
        run_instr(6'b000000, 6'b100010, 2);
        check_trace("rsub", '{0, 1, 6, 7});
        run_instr(6'b000000, 6'b101010, 2);
        trace.delete();

        // beq taken and not taken
        run_instr(6'b000100, 6'd0, 1);
        run_instr(6'b000100, 6'd0, 0);
        check_trace("beq2", '{0, 1, 8, 0, 1, 8});

        // unsupported opcode behaves as a two-cycle nop
        rw0 = regwrite_seen; mw0 = memwrite_seen;
        run_instr(6'b111111, 6'd0, 2);
        check_trace("nop", '{0, 1});
        check("nop_writes", 32'((regwrite_seen - rw0) + (memwrite_seen - mw0)), 32'd0);

        // addi
        run_instr(6'b001000, 6'd0, 2);
        check_trace("addi", '{0, 1, 9, 10});

        // reset held three cycles while in EXECUTE aborts the R-type
        rw0    = regwrite_seen;
        opcode = 6'b000000;
        funct  = 6'b100000;
        Zero   = 1'b0;
        step(M_FULL, model(0, funct, Zero));
        step(M_FULL, model(1, funct, Zero));
        do_reset(3, 6);
        check("abort_regwrites", 32'(regwrite_seen - rw0), 32'd0);
        trace.delete();
        run_instr(6'b000000, 6'b100100, 2);
        check_trace("post_reset", '{0, 1, 6, 7});

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = 6'b100011;
                2:       op = 6'b101011;
                3, 4:    op = 6'b000000;
                5:       op = 6'b000100;
                6:       op = 6'b001000;
                default: op = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 1) == 0) fn = fn_list[$urandom_range(0, 4)];
            else                           fn = 6'($urandom_range(0, 63));
            run_instr(op, fn, 2);
            trace.delete();
        end

        exp_mode = M_NONE;
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
